// File: rtl/fu_credit_alloc.sv
// fu_credit_alloc: credit-based decode FU allocator, all-or-nothing group accept.
// Optional saturating stall counter enabled by FU_ALLOC_STALL_CNT_EN.
module fu_credit_alloc #(
    parameter int MACHINE_WIDTH = 4,
    parameter int NUM_ALU       = 4,
    parameter int RS_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [MACHINE_WIDTH-1:0]   dec_valid,
    input  logic [2*MACHINE_WIDTH-1:0] dec_class,
    input  logic                       flush,
    input  logic [NUM_ALU+2:0]         credit_ret,
    output logic                       dec_ready,
    output logic [3*MACHINE_WIDTH-1:0] alloc_fu_id,
    output logic [MACHINE_WIDTH-1:0]   alloc_valid,
    output logic                       credit_err,
    output logic [31:0]                stall_cnt
);
    localparam int NUM_FU = NUM_ALU + 3;
    localparam int CW     = $clog2(RS_DEPTH + 1);
    localparam int HW     = $clog2(NUM_ALU);

    logic [NUM_FU-1:0][CW-1:0] credit_q, credit_d;
    logic [HW-1:0]             rr_head_q, rr_head_d, last_alu;
    logic                      credit_err_q, credit_err_d;
    logic [NUM_ALU-1:0]        used;
    logic                      ok, alu_hit, found, fire;
    logic [1:0]                cls;
    int                        cons [NUM_FU];
    int                        idx, tmp;

    always_comb begin
        used        = '0;
        ok          = 1'b1;
        alu_hit     = 1'b0;
        last_alu    = '0;
        found       = 1'b0;
        cls         = 2'd0;
        idx         = 0;
        tmp         = 0;
        alloc_fu_id = '0;
        for (int u = 0; u < NUM_FU; u++) cons[u] = 0;
        for (int s = 0; s < MACHINE_WIDTH; s++) begin
            cls   = dec_class[2*s +: 2];
            found = 1'b0;
            if (dec_valid[s]) begin
                if (cls == 2'd0) begin
                    // circular scan from rr_head; an ALU takes at most one slot per cycle
                    for (int k = 0; k < NUM_ALU; k++) begin
                        idx = (int'(rr_head_q) + k) % NUM_ALU;
                        if (!found && !used[idx] && credit_q[idx] != '0) begin
                            found                = 1'b1;
                            used[idx]            = 1'b1;
                            alloc_fu_id[3*s +: 3] = 3'(idx);
                            last_alu             = HW'(idx);
                        end
                    end
                    alu_hit = alu_hit | found;
                    ok      = ok & found;
                end else begin
                    alloc_fu_id[3*s +: 3] = 3'(NUM_ALU + int'(cls) - 1);
                    cons[NUM_ALU + int'(cls) - 1] = cons[NUM_ALU + int'(cls) - 1] + 1;
                end
            end
        end
        for (int u = 0; u < NUM_ALU; u++) cons[u] = int'(used[u]);
        for (int u = NUM_ALU; u < NUM_FU; u++) ok = ok & (cons[u] <= int'(credit_q[u]));
        dec_ready    = ~flush & ok;
        fire         = dec_ready & (|dec_valid);
        credit_err_d = credit_err_q;
        for (int u = 0; u < NUM_FU; u++) begin
            tmp = int'(credit_q[u]) - (fire ? cons[u] : 0) + int'(credit_ret[u]);
            if (tmp > RS_DEPTH) begin
                tmp          = RS_DEPTH;
                credit_err_d = credit_err_d | ~flush;
            end
            credit_d[u] = flush ? CW'(RS_DEPTH) : CW'(tmp);
        end
        rr_head_d = flush ? '0 : (fire && alu_hit) ? HW'((int'(last_alu) + 1) % NUM_ALU) : rr_head_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q     <= {NUM_FU{CW'(RS_DEPTH)}};
            rr_head_q    <= '0;
            credit_err_q <= 1'b0;
        end else begin
            credit_q     <= credit_d;
            rr_head_q    <= rr_head_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign alloc_valid = dec_valid & {MACHINE_WIDTH{dec_ready}};
    assign credit_err  = credit_err_q;

`ifdef FU_ALLOC_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb
        stall_cnt_d = ((|dec_valid) && !dec_ready && !flush && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_fu_credit_alloc.sv
// tb_fu_credit_alloc: table vectors, directed corner sequences and random stimulus vs a queue-based model.
module tb_fu_credit_alloc;
`ifdef FU_ALLOC_STALL_CNT_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  dec_valid = '0;
    logic [7:0]  dec_class = '0;
    logic        flush = 1'b0;
    logic [6:0]  credit_ret = '0;
    logic        dec_ready;
    logic [11:0] alloc_fu_id;
    logic [3:0]  alloc_valid;
    logic        credit_err;
    logic [31:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    int          m_cred [7];
    int          m_use  [7];
    int          m_head, m_last, m_stall;
    logic        m_err, m_rdy;
    logic [11:0] m_ids;

    fu_credit_alloc dut (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_class(dec_class),
        .flush(flush), .credit_ret(credit_ret), .dec_ready(dec_ready),
        .alloc_fu_id(alloc_fu_id), .alloc_valid(alloc_valid),
        .credit_err(credit_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] vmask(input logic [11:0] ids, input logic [3:0] v);
        for (int s = 0; s < 4; s++) if (!v[s]) ids[3*s +: 3] = 3'd0;
        return ids;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 7; u++) m_cred[u] = 4;
        m_head  = 0;
        m_err   = 1'b0;
        m_stall = 0;
    endtask

    // ALUs with credit, listed in rotation order from the head, are handed out front-first
    task automatic model_eval();
        int free_alus[$];
        int a, cl;
        logic ok;
        free_alus = {};
        for (int k = 0; k < 4; k++) begin
            a = (m_head + k) % 4;
            if (m_cred[a] > 0) free_alus.push_back(a);
        end
        for (int u = 0; u < 7; u++) m_use[u] = 0;
        ok     = 1'b1;
        m_last = -1;
        m_ids  = '0;
        for (int s = 0; s < 4; s++) begin
            if (dec_valid[s]) begin
                cl = int'(dec_class[2*s +: 2]);
                if (cl == 0) begin
                    if (free_alus.size() == 0) ok = 1'b0;
                    else begin
                        a = free_alus.pop_front();
                        m_ids[3*s +: 3] = 3'(a);
                        m_use[a]++;
                        m_last = a;
                    end
                end else begin
                    m_ids[3*s +: 3] = 3'(3 + cl);
                    m_use[3 + cl]++;
                end
            end
        end
        for (int u = 4; u < 7; u++) if (m_use[u] > m_cred[u]) ok = 1'b0;
        m_rdy = ok & ~flush;
    endtask

    task automatic model_update();
        int n;
        logic fire;
        fire = m_rdy & (|dec_valid);
        if (SC && (|dec_valid) && !m_rdy && !flush) m_stall++;
        if (flush) begin
            for (int u = 0; u < 7; u++) m_cred[u] = 4;
            m_head = 0;
        end else begin
            for (int u = 0; u < 7; u++) begin
                n = m_cred[u] - (fire ? m_use[u] : 0) + int'(credit_ret[u]);
                if (n > 4) begin
                    n     = 4;
                    m_err = 1'b1;
                end
                m_cred[u] = n;
            end
            if (fire && m_last >= 0) m_head = (m_last + 1) % 4;
        end
    endtask

    task automatic apply(input logic [3:0] v, input logic [7:0] c, input logic fl, input logic [6:0] r);
        dec_valid  = v;
        dec_class  = c;
        flush      = fl;
        credit_ret = r;
        #1;
        model_eval();
    endtask

    task automatic model_check();
        chk("ready", 32'(dec_ready), 32'(m_rdy));
        chk("alloc_valid", 32'(alloc_valid), 32'(dec_valid & {4{m_rdy}}));
        if (m_rdy) chk("fu_id", 32'(vmask(alloc_fu_id, dec_valid)), 32'(vmask(m_ids, dec_valid)));
        chk("credit_err", 32'(credit_err), 32'(m_err));
        chk("stall_cnt", stall_cnt, 32'(m_stall));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        dec_valid  = '0;
        flush      = 1'b0;
        credit_ret = '0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  v;
        logic [7:0]  c;
        logic        fl;
        logic [6:0]  r;
        logic        rdy;
        logic [11:0] ids;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{4'hF, 8'h00, 1'b0, 7'h00, 1'b1, 12'h688};
        tbl[1] = '{4'hF, 8'hC4, 1'b0, 7'h00, 1'b1, 12'hC60};
        tbl[2] = '{4'hF, 8'hC4, 1'b0, 7'h00, 1'b1, 12'hCE2};
        tbl[3] = '{4'h3, 8'h05, 1'b0, 7'h00, 1'b1, 12'h024};
        tbl[4] = '{4'h3, 8'h05, 1'b0, 7'h00, 1'b0, 12'h024};
        tbl[5] = '{4'h3, 8'h05, 1'b0, 7'h10, 1'b0, 12'h024};
        tbl[6] = '{4'h3, 8'h05, 1'b0, 7'h10, 1'b0, 12'h024};
        tbl[7] = '{4'h3, 8'h05, 1'b0, 7'h00, 1'b1, 12'h024};

        @(negedge clk);
        do_reset();
        chk("reset_ready_idle", 32'(dec_ready), 32'd1);
        chk("reset_err", 32'(credit_err), 32'd0);
        chk("reset_stall_cnt", stall_cnt, 32'd0);

        for (int i = 0; i < 8; i++) begin
            apply(tbl[i].v, tbl[i].c, tbl[i].fl, tbl[i].r);
            chk($sformatf("tbl%0d_ready", i), 32'(dec_ready), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_valid", i), 32'(alloc_valid), 32'(tbl[i].v & {4{tbl[i].rdy}}));
            chk($sformatf("tbl%0d_ids", i), 32'(vmask(alloc_fu_id, tbl[i].v)), 32'(vmask(tbl[i].ids, tbl[i].v)));
            tick();
        end

        // drain every ALU, then refill only ALU_2/ALU_3
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(4'hF, 8'h00, 1'b0, 7'h00);
            model_check();
            tick();
        end
        apply(4'h1, 8'h00, 1'b0, 7'h00);
        chk("all_alu_zero_stall", 32'(dec_ready), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(4'h0, 8'h00, 1'b0, 7'h0C);
            model_check();
            tick();
        end
        apply(4'h7, 8'h00, 1'b0, 7'h00);
        chk("two_free_three_alu_stall", 32'(dec_ready), 32'd0);
        tick();
        apply(4'h3, 8'h00, 1'b0, 7'h00);
        chk("two_alu_ready", 32'(dec_ready), 32'd1);
        chk("two_alu_ids", 32'(alloc_fu_id[5:0]), 32'({3'd3, 3'd2}));
        model_check();
        tick();
        apply(4'h1, 8'h00, 1'b0, 7'h00);
        chk("head_wrapped_id", 32'(alloc_fu_id[2:0]), 32'd2);
        model_check();
        tick();

        apply(4'hF, 8'h00, 1'b1, 7'h7F);
        chk("flush_ready", 32'(dec_ready), 32'd0);
        chk("flush_valid", 32'(alloc_valid), 32'd0);
        tick();
        apply(4'hF, 8'h00, 1'b0, 7'h00);
        chk("post_flush_err", 32'(credit_err), 32'd0);
        chk("post_flush_ready", 32'(dec_ready), 32'd1);
        chk("post_flush_ids", 32'(alloc_fu_id), 32'h688);
        tick();

        apply(4'h0, 8'h00, 1'b0, 7'h20);
        tick();
        apply(4'h0, 8'h00, 1'b0, 7'h00);
        chk("overflow_err_set", 32'(credit_err), 32'd1);
        tick();
        tick();
        chk("overflow_err_sticky", 32'(credit_err), 32'd1);
        model_check();

        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(4'h3, 8'h05, 1'b0, 7'h00);
            model_check();
            tick();
        end
        apply(4'h0, 8'h00, 1'b0, 7'h00);
        chk("stall_cnt_three", stall_cnt, SC ? 32'd3 : 32'd0);

        apply(4'h3, 8'h05, 1'b0, 7'h00);
        chk("pre_reset_stall", 32'(dec_ready), 32'd0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        apply(4'h3, 8'h05, 1'b0, 7'h00);
        chk("reset_mid_stall_ready", 32'(dec_ready), 32'd1);
        chk("reset_mid_stall_cnt", stall_cnt, 32'd0);
        model_check();
        tick();

        for (int i = 0; i < 600; i++) begin
            apply(4'($urandom_range(0, 15)), 8'($urandom), ($urandom_range(0, 15) == 0),
                  7'($urandom) & 7'($urandom));
            model_check();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
